// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I-subset controller:
// opcodes, FSM state encoding, ALUOp/ALUControl/ImmSrc codes and
// the per-state Moore control word.
package multicycle_controller_pkg;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALUCTL_ADD = 3'b000;
    localparam logic [2:0] ALUCTL_SUB = 3'b001;
    localparam logic [2:0] ALUCTL_AND = 3'b010;
    localparam logic [2:0] ALUCTL_OR  = 3'b011;
    localparam logic [2:0] ALUCTL_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Moore control word; everything here depends on the state alone.
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        aluop_t     alu_op;
        logic       reg_write;
    } ctrl_t;

    // Control word asserted while the FSM sits in state s.
    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.pc_update  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Immediate format selection, independent of the FSM state.
    function automatic logic [1:0] imm_src_for(logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and Zero flow into the
// controller, selects/enables and debug state flow out.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       Illegal;
    logic [3:0] state_o;

    // Controller side.
    modport master (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ALUControl, ImmSrc, RegWrite, Illegal, state_o
    );

    // Datapath side.
    modport slave (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ALUControl, ImmSrc, RegWrite, Illegal, state_o
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction function fields to ALUControl.
module mc_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  aluop_t     alu_op,
    input  logic [2:0] funct3,
    input  logic       op_b5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Subtract only for R-type (op[5]=1) with funct7[5] set; addi stays add.
    always_comb begin
        alu_control = ALUCTL_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op_b5 && funct7b5) ? ALUCTL_SUB : ALUCTL_ADD;
                    3'b010:  alu_control = ALUCTL_SLT;
                    3'b110:  alu_control = ALUCTL_OR;
                    3'b111:  alu_control = ALUCTL_AND;
                    default: alu_control = ALUCTL_ADD;
                endcase
            end
            default: alu_control = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM. The state and its Moore control word
// are registered together; only PCWrite (Zero), ALUControl/ImmSrc
// (instruction fields) and the DECODE-time Illegal flag see inputs directly.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    multicycle_controller_if.master bus
);

    state_t     state;
    state_t     state_nxt;
    ctrl_t      ctrl_q;
    logic [2:0] alu_control;

    function automatic logic op_supported(logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_ITYPE) || (op == OP_JAL) || (op == OP_BEQ);
    endfunction

    function automatic state_t next_state(state_t s, logic [6:0] op);
        case (s)
            S_FETCH: return S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: return S_MEMADR;
                    OP_RTYPE:     return S_EXECUTER;
                    OP_ITYPE:     return S_EXECUTEI;
                    OP_JAL:       return S_JAL;
                    OP_BEQ:       return S_BEQ;
                    default:      return S_FETCH;
                endcase
            end
            S_MEMADR:   return (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  return S_MEMWB;
            S_EXECUTER,
            S_EXECUTEI,
            S_JAL:      return S_ALUWB;
            default:    return S_FETCH;
        endcase
    endfunction

    assign state_nxt = next_state(state, bus.op);

    // State register with the control word for that state registered alongside.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_FETCH;
            ctrl_q <= state_ctrl(S_FETCH);
        end else begin
            state  <= state_nxt;
            ctrl_q <= state_ctrl(state_nxt);
        end
    end

    mc_alu_decoder u_alu_dec (
        .alu_op      (ctrl_q.alu_op),
        .funct3      (bus.funct3),
        .op_b5       (bus.op[5]),
        .funct7b5    (bus.funct7b5),
        .alu_control (alu_control)
    );

    // Enables are qualified by reset_n: the registered word holds the FETCH
    // values during reset, but no write may happen until reset is released.
    assign bus.PCWrite    = reset_n & (ctrl_q.pc_update | (ctrl_q.branch & bus.Zero));
    assign bus.IRWrite    = reset_n & ctrl_q.ir_write;
    assign bus.MemWrite   = reset_n & ctrl_q.mem_write;
    assign bus.RegWrite   = reset_n & ctrl_q.reg_write;
    assign bus.AdrSrc     = ctrl_q.adr_src;
    assign bus.ResultSrc  = ctrl_q.result_src;
    assign bus.ALUSrcA    = ctrl_q.alu_src_a;
    assign bus.ALUSrcB    = ctrl_q.alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = imm_src_for(bus.op);
    // The opcode only becomes valid in DECODE (IR loads at the end of FETCH),
    // so the illegal-op flag is qualified by the current state.
    assign bus.Illegal    = (state == S_DECODE) && !op_supported(bus.op);
    assign bus.state_o    = state;

endmodule
